// File: rtl/xs3_pkg.sv
// Shared types and constants for the excess-3 digit packer.
package xs3_pkg;

    // Packer control states: accumulating digits, discarding overflow digits,
    // and presenting a completed number downstream.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Legal excess-3 code range (digits 0..9).
    localparam logic [3:0] XS3_MIN = 4'd3;
    localparam logic [3:0] XS3_MAX = 4'd12;

    // Bit positions inside the 2-bit error flag vector.
    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_OVF     = 1;

endpackage

// File: rtl/xs3_digit_decode.sv
// Combinational excess-3 to BCD digit decoder with illegal-code detection.
// Illegal codes decode to digit 0 so the downstream arithmetic stays defined.
module xs3_digit_decode
    import xs3_pkg::*;
(
    input  logic [3:0] in_xs3,
    output logic [3:0] o_digit,
    output logic       o_illegal
);

    // Range-check the code and subtract the excess-3 bias.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_digit   = 4'd0;
        o_illegal = 1'b0;
        if ((in_xs3 < XS3_MIN) || (in_xs3 > XS3_MAX)) begin
            o_illegal = 1'b1;
        end else begin
            o_digit = in_xs3 - XS3_MIN;
        end
    end

endmodule

// File: rtl/xs3_bcd_packer.sv
// Packs a serial stream of excess-3 digits into a right-aligned packed-BCD
// word, tracks its binary value, and presents the result on a registered
// valid/ready output. Output registers only change when a number is
// completed (entry to HOLD) or when the consumer takes it.
module xs3_bcd_packer
    import xs3_pkg::*;
#(
    parameter  int DIGITS = 4,
    parameter  int BIN_W  = 14,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_xs3,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [BIN_W-1:0]      out_bin,
    output logic [CNT_W-1:0]      out_count,
    output logic [1:0]            out_err
);

    // Working accumulators for the number being assembled.
    state_t               r_state;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [BIN_W-1:0]     r_bin;
    logic [CNT_W-1:0]     r_count;
    logic [1:0]           r_err;

    // Registered output copies presented while in HOLD.
    logic                 r_out_valid;
    logic [4*DIGITS-1:0]  r_out_bcd;
    logic [BIN_W-1:0]     r_out_bin;
    logic [CNT_W-1:0]     r_out_count;
    logic [1:0]           r_out_err;

    logic [3:0]           w_digit;
    logic                 w_illegal;
    logic [4*DIGITS-1:0]  w_bcd_next;
    logic [BIN_W-1:0]     w_bin_next;
    logic [BIN_W-1:0]     w_digit_bin;
    logic [CNT_W-1:0]     w_count_next;
    logic [1:0]           w_err_accum;
    logic [1:0]           w_err_drain;

    xs3_digit_decode u_decode (
        .in_xs3    (in_xs3),
        .o_digit   (w_digit),
        .o_illegal (w_illegal)
    );

    // Next values of the accumulators for a digit accepted in ACCUM.
    // The x10 uses shifts and an add so no multiplier is needed.
    always_comb begin
        w_digit_bin  = BIN_W'(w_digit);
        w_bcd_next   = (r_bcd << 4) | (4*DIGITS)'(w_digit);
        w_bin_next   = (r_bin << 3) + (r_bin << 1) + w_digit_bin;
        w_count_next = r_count + CNT_W'(1);
        w_err_accum  = r_err;
        w_err_accum[ERR_ILLEGAL] = r_err[ERR_ILLEGAL] | w_illegal;
        w_err_drain  = r_err;
        w_err_drain[ERR_OVF] = 1'b1;
    end

    // Ready depends only on the state register, never on in_valid/out_ready.
    assign in_ready = (r_state != HOLD);

    // Control FSM, accumulators and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_bcd       <= '0;
            r_bin       <= '0;
            r_count     <= '0;
            r_err       <= '0;
            r_out_valid <= 1'b0;
            r_out_bcd   <= '0;
            r_out_bin   <= '0;
            r_out_count <= '0;
            r_out_err   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        r_bcd   <= w_bcd_next;
                        r_bin   <= w_bin_next;
                        r_count <= w_count_next;
                        r_err   <= w_err_accum;
                        if (in_last) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_out_bcd   <= w_bcd_next;
                            r_out_bin   <= w_bin_next;
                            r_out_count <= w_count_next;
                            r_out_err   <= w_err_accum;
                        end else if (w_count_next == CNT_W'(DIGITS)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Excess digits are consumed but never stored.
                    if (in_valid) begin
                        r_err <= w_err_drain;
                        if (in_last) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_out_bcd   <= r_bcd;
                            r_out_bin   <= r_bin;
                            r_out_count <= r_count;
                            r_out_err   <= w_err_drain;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= ACCUM;
                        r_bcd       <= '0;
                        r_bin       <= '0;
                        r_count     <= '0;
                        r_err       <= '0;
                        r_out_valid <= 1'b0;
                        r_out_bcd   <= '0;
                        r_out_bin   <= '0;
                        r_out_count <= '0;
                        r_out_err   <= '0;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_bcd   = r_out_bcd;
    assign out_bin   = r_out_bin;
    assign out_count = r_out_count;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_xs3_bcd_packer.sv
// Directed self-checking bench for xs3_bcd_packer (DIGITS=4, BIN_W=14).
module tb_xs3_bcd_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_xs3;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [13:0] out_bin;
    logic [2:0]  out_count;
    logic [1:0]  out_err;

    int checks;
    int errors;

    xs3_bcd_packer #(.DIGITS(4), .BIN_W(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_xs3    (in_xs3),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_bin   (out_bin),
        .out_count (out_count),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Present one digit and hold it until accepted; returns #1 after the accept edge.
    task automatic drive_digit(input logic [3:0] x, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_xs3   = x;
        in_last  = last;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Compare every output against a required completed-number value.
    task automatic check_out(input string name, input logic vld, input logic [15:0] bcd,
                             input logic [13:0] bin, input logic [2:0] cnt, input logic [1:0] err);
        checks++;
        if (out_valid !== vld) begin
            errors++;
            $display("FAIL %s_valid: got %b required %b", name, out_valid, vld);
        end
        checks++;
        if (out_bcd !== bcd) begin
            errors++;
            $display("FAIL %s_bcd: got %h required %h", name, out_bcd, bcd);
        end
        checks++;
        if (out_bin !== bin) begin
            errors++;
            $display("FAIL %s_bin: got %0d required %0d", name, out_bin, bin);
        end
        checks++;
        if (out_count !== cnt) begin
            errors++;
            $display("FAIL %s_count: got %0d required %0d", name, out_count, cnt);
        end
        checks++;
        if (out_err !== err) begin
            errors++;
            $display("FAIL %s_err: got %b required %b", name, out_err, err);
        end
    endtask

    task automatic check_ready(input string name, input logic exp);
        checks++;
        if (in_ready !== exp) begin
            errors++;
            $display("FAIL %s_in_ready: got %b required %b", name, in_ready, exp);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_xs3    = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check_out("reset", 1'b0, 16'h0, 14'd0, 3'd0, 2'b00);
        check_ready("reset", 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive_digit(4'b0100, 1'b0);
        drive_digit(4'b0101, 1'b0);
        check_out("basic_midframe", 1'b0, 16'h0, 14'd0, 3'd0, 2'b00);
        drive_digit(4'b0110, 1'b1);
        check_out("basic", 1'b1, 16'h0123, 14'd123, 3'd3, 2'b00);
        check_ready("basic_hold", 1'b0);
        @(posedge clk); #1;
        check_out("basic_cleared", 1'b0, 16'h0, 14'd0, 3'd0, 2'b00);
        check_ready("basic_after", 1'b1);
    endtask

    task automatic test_full_width();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_digit(4'b1100, 1'b0);
        check_ready("full_no_drain", 1'b1);
        drive_digit(4'b1100, 1'b1);
        check_out("full", 1'b1, 16'h9999, 14'd9999, 3'd4, 2'b00);
        @(posedge clk); #1;
        check_ready("full_after", 1'b1);
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive_digit(4'b0100, 1'b0);
        drive_digit(4'b0000, 1'b0);
        drive_digit(4'b0101, 1'b1);
        check_out("illegal", 1'b1, 16'h0102, 14'd102, 3'd3, 2'b01);
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [3:0] seq [6];
        seq = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_digit(seq[i], (i == 5));
            if (i == 3 || i == 4) begin
                check_out("ovf_drain", 1'b0, 16'h0, 14'd0, 3'd0, 2'b00);
                check_ready("ovf_drain", 1'b1);
            end
        end
        check_out("ovf", 1'b1, 16'h1234, 14'd1234, 3'd4, 2'b10);
        @(posedge clk); #1;
        check_out("ovf_cleared", 1'b0, 16'h0, 14'd0, 3'd0, 2'b00);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_digit(4'b0011, 1'b1);
        in_valid = 1'b1;
        in_xs3   = 4'b0100;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_out("bp_hold", 1'b1, 16'h0, 14'd0, 3'd1, 2'b00);
            check_ready("bp_hold", 1'b0);
            @(posedge clk); #1;
        end
        check_out("bp_hold_end", 1'b1, 16'h0, 14'd0, 3'd1, 2'b00);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_out("bp_handshake", 1'b0, 16'h0, 14'd0, 3'd0, 2'b00);
        check_ready("bp_handshake", 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_out("bp_next", 1'b1, 16'h0001, 14'd1, 3'd1, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        drive_digit(4'b0100, 1'b0);
        drive_digit(4'b0101, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("areset", 1'b0, 16'h0, 14'd0, 3'd0, 2'b00);
        check_ready("areset", 1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive_digit(4'b0111, 1'b1);
        check_out("areset_next", 1'b1, 16'h0004, 14'd4, 3'd1, 2'b00);
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_full_width();
        test_illegal();
        test_overflow();
        test_backpressure();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xs3_bcd_packer.md
# xs3_bcd_packer

Sequential stage directly downstream of the excess-3 to BCD digit converter. Accepts a serial stream of excess-3 digits under a valid/ready handshake and decodes each to BCD. Packs up to DIGITS digits of one number into a right-aligned packed-BCD word and computes its binary value on the fly. Presents the completed number, its digit count and error flags on a registered valid/ready output.

## Interface
- DIGITS, 4: maximum BCD digits per number (1..8).
- BIN_W, 14: binary output width; must be ≥ ceil(log2(10^DIGITS)).
- CNT_W, $clog2(DIGITS+1): digit-count width (derived, not overridden).

- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_xs3/in_last valid.
- in_ready  output  1  block accepts a digit this cycle.
- in_xs3  input  4  excess-3 digit.
- in_last  input  1  final digit of the current number.
- out_valid  output  1  completed number available.
- out_ready  input  1  consumer takes the number.
- out_bcd  output  4*DIGITS  packed BCD, right-aligned; first-received digit most significant.
- out_bin  output  BIN_W  binary value of out_bcd.
- out_count  output  CNT_W  digits captured (1..DIGITS).
- out_err  output  2  bit0 illegal code seen, bit1 overflow (more than DIGITS digits).

## Operation
- Digit accept: in_valid && in_ready.
- Decode: BCD = in_xs3 − 3. Legal codes are 0011..1100. An illegal code (0000–0010, 1101–1111) is treated as digit 0 and sets sticky err bit0.
- FSM states: ACCUM, DRAIN, HOLD.
- ACCUM (in_ready=1), on each accept:
  - bcd ← {bcd[4*DIGITS-5:0], digit}.
  - bin ← bin*10 + digit, truncated to BIN_W.
  - count ← count+1.
  - If in_last: go to HOLD.
  - Else if count reaches DIGITS on this accept: go to DRAIN.
- DRAIN (in_ready=1):
  - Accepted digits are discarded; bcd, bin and count are frozen.
  - Any accept sets sticky err bit1.
  - An accept with in_last goes to HOLD.
- HOLD (in_ready=0):
  - out_valid=1; outputs are stable until out_valid && out_ready.
  - On that handshake: bcd, bin, count and err clear to 0, and the FSM goes to ACCUM.
- in_last on the DIGITS-th digit is a normal completion: go directly to HOLD, err bit1 stays 0.
- in_valid while in HOLD: no accept. Upstream holds its data; none is lost.
- Reset mid-frame discards the partial number with no output.

## Timing
- Reset values:
  - state=ACCUM, in_ready=1.
  - out_valid=0, out_bcd=0, out_bin=0, out_count=0, out_err=0.
- All outputs are registered, except in_ready, which is a decode of the state register only (no combinational path from in_valid or out_ready).
- Latency: out_valid rises the cycle after the accept carrying in_last.
- Throughput: one digit per cycle in ACCUM/DRAIN.
- HOLD lasts at least one cycle; out_ready held high gives exactly one HOLD cycle. in_ready returns to 1 the cycle after the output handshake.
- A frame of N digits therefore costs N+1 cycles minimum.
- out_bcd/out_bin/out_count/out_err may change only on entry to HOLD or on the clearing handshake.

## Structure
- Package xs3_pkg:
  - state enum {ACCUM, DRAIN, HOLD}.
  - XS3_MIN=4'd3, XS3_MAX=4'd12.
  - ERR_ILLEGAL=0, ERR_OVF=1.
- Sub-module xs3_digit_decode: combinational; in_xs3 → 4-bit BCD digit plus illegal flag. Instantiated once.
- Top holds the FSM, the shift register, the ×10 accumulator (computed as (bin<<3)+(bin<<1)+digit) and the output registers.

## Test plan
- Reset then digits 0100,0101,0110 (last on third), out_ready=1 → out_valid one cycle after the third accept; out_bcd=16'h0123, out_bin=123, out_count=3, out_err=0; in_ready back to 1 two cycles after the third accept.
- Four digits of 1100 (last on fourth) → out_bcd=16'h9999, out_bin=9999, out_count=4, out_err=0; no DRAIN entry.
- Digits 0100,0000,0101 (last) → out_bcd=16'h0102, out_bin=102, out_err=2'b01.
- Six digits 0100,0101,0110,0111,1000,1001 (last on sixth) → out_bcd=16'h1234, out_bin=1234, out_count=4, out_err=2'b10; the fifth and sixth digits are accepted but dropped.
- One-digit frame 0011 (last), out_ready held 0 for 5 cycles with in_valid high → outputs stable at 0/0/1/0, in_ready=0 throughout; the next digit is accepted only after the handshake.
- rst_n pulsed low asynchronously after two digits → all outputs are at their reset values immediately. The next frame 0111 (last) yields out_bcd=16'h0004, out_bin=4, out_count=1.
